fsm_stim_sig: RTL and testbench
===============================

Name: fsm_stim_sig

Overview:
- Self-contained stimulus driver and response compactor for the 5-input / 20-output benchmark controller FSMs in this suite.
- Drives pseudo-random x1..x5 from an LFSR and compacts y1..y20 into a 20-bit MISR signature.
- Golden-vs-suspect signature comparison exposes payloads that silence outputs after N visits.
- Sits beside the DUT in the benchmark harness: drives the DUT's inputs and receives its outputs.

Parameters:
- NUM_CYCLES, 256: RUN-phase length in clocks; legal range 1..65535.
- SEED, 16'hACE1: default LFSR seed; also substituted whenever a zero seed is loaded.
- DUT_RST_CYC, 2: clocks dut_rst is held high before RUN; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- seed_load  in  1  loads seed_in into the LFSR; honoured only in IDLE/DONE.
- seed_in  in  16  seed value.
- x_out  out  5  DUT stimulus; x_out[0]=x1 .. x_out[4]=x5.
- dut_rst  out  1  registered reset to the DUT.
- y_in  in  20  DUT outputs; y_in[0]=y1 .. y_in[19]=y20.
- busy  out  1  high in RESET_DUT and RUN.
- done  out  1  high in DONE.
- signature  out  20  MISR value; stable in DONE.
- cycles_run  out  16  RUN cycles completed in the current or last run.

Behaviour:
- Reset values: state=IDLE; lfsr=SEED; misr=0; x_out=0; dut_rst=0; busy=0; done=0; cycles_run=0.
- FSM states and transitions:
  - IDLE: start moves to RESET_DUT.
  - RESET_DUT: dut_rst=1 for exactly DUT_RST_CYC clocks, then RUN. misr and cycles_run clear on entry. x_out=lfsr[4:0] is driven throughout.
  - RUN: lasts exactly NUM_CYCLES clocks, then DONE. dut_rst=0.
  - DONE: start moves to RESET_DUT. done stays high until then.
- RUN cycle k (k=0..NUM_CYCLES-1):
  - x_out = lfsr[4:0] for the whole cycle.
  - At the closing rising edge: misr <= {misr[18:0], misr[19]^misr[16]} ^ y_in; lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; cycles_run increments.
  - The DUT updates state on falling clk edges, so the y_in sampled at the rising edge reflects the DUT's response to the current x_out.
- x_out holds its last RUN value in DONE and is 0 in IDLE.
- LFSR persistence: the LFSR is not re-seeded between runs; it continues from its last value unless seed_load is asserted.
- seed_load: seed_in==0 loads SEED (avoids lock-up). seed_load and start in the same cycle: the seed loads first, then the run starts from the new seed. seed_load in RESET_DUT/RUN is ignored.
- start during busy is ignored.
- Counter width: cycles_run saturates at 16'hFFFF and never wraps.
- rst mid-run: immediate return to IDLE with reset values; a partial signature is discarded.

Optional Feature:
- Macro: ACTIVITY_CNT_EN.
- Defined: adds output active_cnt[15:0]. It clears on RESET_DUT entry, increments at each RUN closing edge where y_in != 0, saturates at 16'hFFFF, and holds in DONE. A drop relative to a golden run flags output-suppression payloads.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: after rst release, all outputs read 0 and state is IDLE. With start held low for 10 clocks, busy stays 0 and x_out stays 0.
- LFSR sequence: seed_load with seed_in=16'hACE1, start. After dut_rst is high for 2 clocks, RUN cycle 0 shows x_out=5'h01 and cycle 1 shows x_out=5'h03.
- MISR compaction: y_in tied to 20'h00001. NUM_CYCLES=1 gives signature=20'h00001; NUM_CYCLES=2 gives signature=20'h00003. With y_in tied to 0, signature=0.
- Zero-seed handling: seed_load with seed_in=0 gives the same x_out sequence as seed 16'hACE1. Also check that start while busy is ignored and cycles_run=NUM_CYCLES in DONE.
- Reset mid-run: rst asserted at RUN cycle 100 gives IDLE, signature=0, cycles_run=0. A rerun from the same seed reproduces the uninterrupted signature.
- ACTIVITY_CNT_EN: y_in nonzero on exactly 7 of 16 RUN cycles gives active_cnt=7 in DONE.

Source files
------------

// File: rtl/fsm_stim_sig.sv
// Stimulus driver (LFSR -> x_out) and 20-bit MISR response compactor for the benchmark controller FSMs.
// Define ACTIVITY_CNT_EN to add active_cnt, a count of RUN cycles with nonzero y_in.
module fsm_stim_sig #(
  parameter int          NUM_CYCLES  = 256,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          DUT_RST_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic [4:0]  x_out,
  output logic        dut_rst,
  input  logic [19:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [19:0] signature,
  output logic [15:0] cycles_run
`ifdef ACTIVITY_CNT_EN
  ,
  output logic [15:0] active_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RESET_DUT, S_RUN, S_DONE} state_t;

  localparam logic [15:0] LAST_RUN = 16'(NUM_CYCLES - 1);
  localparam logic [3:0]  LAST_RST = 4'(DUT_RST_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [19:0] misr_q, misr_d;
  logic [15:0] cyc_q, cyc_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [4:0]  x_last_q, x_last_d;
  logic        dut_rst_q, dut_rst_d;
`ifdef ACTIVITY_CNT_EN
  logic [15:0] act_q, act_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      misr_q    <= '0;
      cyc_q     <= '0;
      rcnt_q    <= '0;
      x_last_q  <= '0;
      dut_rst_q <= 1'b0;
`ifdef ACTIVITY_CNT_EN
      act_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      cyc_q     <= cyc_d;
      rcnt_q    <= rcnt_d;
      x_last_q  <= x_last_d;
      dut_rst_q <= dut_rst_d;
`ifdef ACTIVITY_CNT_EN
      act_q     <= act_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cyc_d    = cyc_q;
    rcnt_d   = rcnt_q;
    x_last_d = x_last_q;
`ifdef ACTIVITY_CNT_EN
    act_d    = act_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A zero seed would lock the LFSR at zero, so fall back to SEED.
        if (seed_load) lfsr_d = (seed_in == 16'h0) ? SEED : seed_in;
        if (start) begin
          state_d = S_RESET_DUT;
          rcnt_d  = '0;
          misr_d  = '0;
          cyc_d   = '0;
`ifdef ACTIVITY_CNT_EN
          act_d   = '0;
`endif
        end
      end
      S_RESET_DUT: begin
        if (rcnt_q == LAST_RST) state_d = S_RUN;
        else                    rcnt_d  = rcnt_q + 4'd1;
      end
      S_RUN: begin
        misr_d   = {misr_q[18:0], misr_q[19] ^ misr_q[16]} ^ y_in;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        x_last_d = lfsr_q[4:0];
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`ifdef ACTIVITY_CNT_EN
        if ((y_in != 20'h0) && (act_q != 16'hFFFF)) act_d = act_q + 16'd1;
`endif
        if (cyc_q == LAST_RUN) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    dut_rst_d = (state_d == S_RESET_DUT);
  end

  // DONE shows the last applied stimulus, not the already-advanced LFSR.
  always_comb begin
    x_out = 5'h0;
    case (state_q)
      S_RESET_DUT, S_RUN: x_out = lfsr_q[4:0];
      S_DONE:             x_out = x_last_q;
      default:            x_out = 5'h0;
    endcase
  end

  assign dut_rst    = dut_rst_q;
  assign busy       = (state_q == S_RESET_DUT) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign signature  = misr_q;
  assign cycles_run = cyc_q;
`ifdef ACTIVITY_CNT_EN
  assign active_cnt = act_q;
`endif

endmodule

// File: tb/tb_fsm_stim_sig.sv
// Bench for fsm_stim_sig: directed run sequence with random/patterned y_in against a reference model.
module tb_fsm_stim_sig;
  localparam int NC = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [4:0]  x_out;
  logic        dut_rst;
  logic [19:0] y_in;
  logic        busy;
  logic        done;
  logic [19:0] signature;
  logic [15:0] cycles_run;
`ifdef ACTIVITY_CNT_EN
  logic [15:0] active_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr;
  logic [19:0] m_misr;
  int          m_act;
  logic [4:0]  m_x;
  logic [19:0] golden;

  always #5 clk = ~clk;

  fsm_stim_sig #(.NUM_CYCLES(NC), .SEED(16'hACE1), .DUT_RST_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .x_out(x_out), .dut_rst(dut_rst), .y_in(y_in), .busy(busy), .done(done),
    .signature(signature), .cycles_run(cycles_run)
`ifdef ACTIVITY_CNT_EN
    , .active_cnt(active_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // 0: random, 1: constant 1, 2: zero, 3: nonzero on 7 cycles, 4: repeatable pattern
  function automatic logic [19:0] y_pat(input int mode, input int k);
    logic [31:0] h;
    case (mode)
      0: return 20'($urandom);
      1: return 20'h00001;
      2: return 20'h00000;
      3: return ((k % 17) == 3) ? (20'h1 << (k % 20)) : 20'h0;
      default: begin
        h = 32'(k + 1) * 32'h9E3779B1;
        return h[28:9];
      end
    endcase
  endfunction

  task automatic idle_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_x"}, 32'(x_out), 0);
    chk({tag, "_dutrst"}, 32'(dut_rst), 0);
    chk({tag, "_sig"}, 32'(signature), 0);
    chk({tag, "_cyc"}, 32'(cycles_run), 0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run(input bit do_load, input logic [15:0] sd, input int ymode, input int abort_at);
    logic [19:0] y;
    int n;
    start = 1'b1; seed_load = do_load; seed_in = sd;
    if (do_load) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    m_misr = '0; m_act = 0;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    n = 0;
    while (dut_rst === 1'b1 && n < 20) begin
      chk("rst_x", 32'(x_out), 32'(m_lfsr[4:0]));
      chk("rst_busy", 32'(busy), 1);
      n++;
      @(negedge clk);
    end
    chk("rst_len", 32'(n), 2);
    for (int k = 0; k < NC; k++) begin
      chk("run_busy", 32'(busy), 1);
      chk("run_dutrst", 32'(dut_rst), 0);
      chk("run_x", 32'(x_out), 32'(m_lfsr[4:0]));
      chk("run_sig", 32'(signature), 32'(m_misr));
      chk("run_cyc", 32'(cycles_run), 32'(k));
      if (do_load && (sd == 16'hACE1 || sd == 16'h0) && k == 0) chk("x_k0", 32'(x_out), 32'h01);
      if (do_load && (sd == 16'hACE1 || sd == 16'h0) && k == 1) chk("x_k1", 32'(x_out), 32'h03);
      if (ymode == 1 && k == 1) chk("misr_1cyc", 32'(signature), 32'h00001);
      if (ymode == 1 && k == 2) chk("misr_2cyc", 32'(signature), 32'h00003);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        idle_check("abort");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0; seed_load = 1'b0; y_in = '0;
        m_lfsr = 16'hACE1; m_misr = '0; m_act = 0; m_x = '0;
        @(negedge clk);
        idle_check("post_abort");
        return;
      end
      // start and seed_load while busy must both be ignored
      start = (k == 5);
      seed_load = (k == 7);
      seed_in = 16'h1234;
      y = y_pat(ymode, k);
      y_in = y;
      m_x = m_lfsr[4:0];
      if (y != 20'h0 && m_act < 65535) m_act++;
      m_misr = {m_misr[18:0], m_misr[19] ^ m_misr[16]} ^ y;
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge clk);
    end
    start = 1'b0; seed_load = 1'b0; y_in = '0;
    chk("done_done", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_dutrst", 32'(dut_rst), 0);
    chk("done_sig", 32'(signature), 32'(m_misr));
    chk("done_cyc", 32'(cycles_run), NC);
    chk("done_x", 32'(x_out), 32'(m_x));
`ifdef ACTIVITY_CNT_EN
    chk("done_act", 32'(active_cnt), 32'(m_act));
`endif
    y_in = y_pat(0, 0);
    @(negedge clk);
    chk("hold_done", 32'(done), 1);
    chk("hold_sig", 32'(signature), 32'(m_misr));
    chk("hold_x", 32'(x_out), 32'(m_x));
    y_in = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = '0; y_in = '0;
    m_lfsr = 16'hACE1; m_misr = '0; m_act = 0; m_x = '0; golden = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check("reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_x", 32'(x_out), 0);
    end

    run(1'b1, 16'hACE1, 1, -1);
    run(1'b0, 16'h0000, 0, -1);
    run(1'b1, 16'h0000, 2, -1);
    chk("zero_y_sig", 32'(signature), 0);

    run(1'b1, 16'hACE1, 4, -1);
    golden = m_misr;
    run(1'b1, 16'hACE1, 4, 100);
    run(1'b1, 16'hACE1, 4, -1);
    chk("rerun_sig", 32'(signature), 32'(golden));

    run(1'b1, 16'h5A5A, 3, -1);
`ifdef ACTIVITY_CNT_EN
    chk("act7", 32'(active_cnt), 7);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
